// File: rtl/uart_receiver.sv
// uart_receiver: UART receive path. Synchronises the raw RX pin, recovers frames
// with 16x oversampling and mid-bit sampling, and buffers bytes in a show-ahead FIFO.
// Optional build macro UART_RX_PARITY_EN: 8E1 framing with a live parity_err flag;
// undefined (default): 8N1 framing and parity_err tied low.
module uart_receiver #(
    parameter int unsigned CLK_FREQ   = 25000000,
    parameter int unsigned BAUD_RATE  = 9600,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          rx,
    input  logic                          rd_en,
    input  logic                          err_clr,
    output logic [7:0]                    rx_data,
    output logic                          rx_valid,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overrun,
    output logic                          frame_err,
    output logic                          parity_err
);

    localparam int unsigned Div  = (CLK_FREQ + BAUD_RATE * 8) / (BAUD_RATE * 16);
    localparam int unsigned DivW = (Div > 1) ? $clog2(Div) : 1;
    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
`ifdef UART_RX_PARITY_EN
        StParity,
`endif
        StStop,
        StBreak
    } state_e;

    state_e            r_state;
    state_e            w_state_next;
    logic              r_rx_meta;
    logic              r_rxs;
    logic [DivW-1:0]   r_div_cnt;
    logic              w_tick;
    logic [3:0]        r_sc;
    logic [2:0]        r_bit_cnt;
    logic [7:0]        r_shift;
    logic              w_start;
    logic              w_sc_clr;
    logic              w_shift_en;
    logic              w_push_req;
    logic              w_frame_set;
    logic              w_par_set;
    logic [7:0]        r_mem [FIFO_DEPTH];
    logic [PtrW-1:0]   r_wr_ptr;
    logic [PtrW-1:0]   r_rd_ptr;
    logic [CntW-1:0]   r_count;
    logic              w_full;
    logic              w_pop;
    logic              w_push;
    logic              w_ovr_set;
    logic              r_overrun;
    logic              r_frame_err;

    // Two-flop synchroniser on the asynchronous RX pin; idles high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_meta <= 1'b1;
            r_rxs     <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rxs     <= r_rx_meta;
        end
    end

    assign w_tick = (r_div_cnt == DivW'(Div - 1));

    // Oversampling tick divider; restarted on the start edge so ticks align to it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div_cnt <= '0;
        end else if (w_start || w_tick) begin
            r_div_cnt <= '0;
        end else begin
            r_div_cnt <= r_div_cnt + DivW'(1);
        end
    end

    // Frame FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Frame FSM next-state and datapath control.
    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_sc_clr     = 1'b0;
        w_shift_en   = 1'b0;
        w_push_req   = 1'b0;
        w_frame_set  = 1'b0;
        w_par_set    = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (!r_rxs) begin
                    w_start      = 1'b1;
                    w_sc_clr     = 1'b1;
                    w_state_next = StStart;
                end
            end
            StStart: begin
                if (w_tick && r_sc == 4'd7) begin
                    if (!r_rxs) begin
                        w_sc_clr     = 1'b1;
                        w_state_next = StData;
                    end else begin
                        // Start bit gone by mid-bit: a glitch, not a frame.
                        w_state_next = StIdle;
                    end
                end
            end
            StData: begin
                if (w_tick && r_sc == 4'd15) begin
                    w_shift_en = 1'b1;
                    if (r_bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        w_state_next = StParity;
`else
                        w_state_next = StStop;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            StParity: begin
                if (w_tick && r_sc == 4'd15) begin
                    // Even parity: data bits plus parity bit must XOR to zero.
                    w_par_set    = (^r_shift) ^ r_rxs;
                    w_state_next = StStop;
                end
            end
`endif
            StStop: begin
                if (w_tick && r_sc == 4'd15) begin
                    if (r_rxs) begin
                        w_push_req   = 1'b1;
                        w_state_next = StIdle;
                    end else begin
                        w_frame_set  = 1'b1;
                        w_state_next = StBreak;
                    end
                end
            end
            StBreak: begin
                // Hold here while the line stays low so a break is not seen as frames.
                if (r_rxs) begin
                    w_state_next = StIdle;
                end
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    // Sample counter, bit counter and LSB-first shift register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sc      <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
        end else begin
            if (w_sc_clr) begin
                r_sc      <= '0;
                r_bit_cnt <= '0;
            end else begin
                if (w_tick) begin
                    r_sc <= r_sc + 4'd1;
                end
                if (w_shift_en) begin
                    r_bit_cnt <= r_bit_cnt + 3'd1;
                end
            end
            if (w_shift_en) begin
                r_shift <= {r_rxs, r_shift[7:1]};
            end
        end
    end

    assign w_full    = (r_count == CntW'(FIFO_DEPTH));
    assign w_pop     = rd_en && rx_valid;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign w_push    = w_push_req && (!w_full || w_pop);
    assign w_ovr_set = w_push_req && w_full && !w_pop;

    // FIFO storage; contents are don't-care until pushed.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= r_shift;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PtrW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PtrW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CntW'(1);
                2'b01:   r_count <= r_count - CntW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky error flags; a set event wins over a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overrun   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            if (w_ovr_set) begin
                r_overrun <= 1'b1;
            end else if (err_clr) begin
                r_overrun <= 1'b0;
            end
            if (w_frame_set) begin
                r_frame_err <= 1'b1;
            end else if (err_clr) begin
                r_frame_err <= 1'b0;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    logic r_parity_err;

    // Sticky parity error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_parity_err <= 1'b0;
        end else if (w_par_set) begin
            r_parity_err <= 1'b1;
        end else if (err_clr) begin
            r_parity_err <= 1'b0;
        end
    end

    assign parity_err = r_parity_err;
`else
    assign parity_err = 1'b0;
`endif

    assign rx_valid   = (r_count != '0);
    assign rx_data    = rx_valid ? r_mem[r_rd_ptr] : 8'h00;
    assign fifo_count = r_count;
    assign overrun    = r_overrun;
    assign frame_err  = r_frame_err;

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: hand sequences, a vector table and a
// randomized run against a queue-based reference model.
module tb_uart_receiver;

    localparam int unsigned ClkFreq = 6400000;
    localparam int unsigned Baud    = 100000;
    localparam int unsigned Depth   = 4;
    localparam int unsigned Div     = 4;
    localparam int unsigned BitClk  = 64;
`ifdef UART_RX_PARITY_EN
    localparam int unsigned StopTick = 168;
`else
    localparam int unsigned StopTick = 152;
`endif
    // Posedge index (start edge driven just before posedge 0) of the stop sample.
    localparam int unsigned StopPos = 2 + Div * StopTick;

    logic       clk;
    logic       rst_n;
    logic       rx;
    logic       rd_en;
    logic       err_clr;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [2:0] fifo_count;
    logic       overrun;
    logic       frame_err;
    logic       parity_err;

    int checks   = 0;
    int failures = 0;

    logic [7:0] mq[$];
    logic       m_ovr;
    logic       m_fe;

    typedef struct {
        logic [7:0]  data;
        int unsigned bclk;
        logic [2:0]  exp_count;
        logic [7:0]  exp_head;
        logic        exp_ovr;
    } vec_t;

    vec_t vecs [5];

    uart_receiver #(
        .CLK_FREQ   (ClkFreq),
        .BAUD_RATE  (Baud),
        .FIFO_DEPTH (Depth)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx),
        .rd_en      (rd_en),
        .err_clr    (err_clr),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .fifo_count (fifo_count),
        .overrun    (overrun),
        .frame_err  (frame_err),
        .parity_err (parity_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_state(input string name, input logic valid, input logic [7:0] data,
                               input logic [2:0] cnt, input logic ovr, input logic fe);
        check({name, ".rx_valid"}, 32'(rx_valid), 32'(valid));
        check({name, ".rx_data"}, 32'(rx_data), 32'(data));
        check({name, ".fifo_count"}, 32'(fifo_count), 32'(cnt));
        check({name, ".overrun"}, 32'(overrun), 32'(ovr));
        check({name, ".frame_err"}, 32'(frame_err), 32'(fe));
        check({name, ".parity_err"}, 32'(parity_err), 32'(0));
    endtask

    task automatic compare_model(input string name);
        check_state(name, mq.size() != 0, (mq.size() != 0) ? mq[0] : 8'h00,
                    3'(mq.size()), m_ovr, m_fe);
    endtask

    task automatic idle(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    // Caller is at a negedge; drives one frame, stop level held for stop_len clocks.
    task automatic send_frame(input logic [7:0] b, input int unsigned bclk, input logic stop,
                              input int unsigned stop_len);
        rx = 1'b0;
        idle(bclk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            idle(bclk);
        end
`ifdef UART_RX_PARITY_EN
        rx = ^b;
        idle(bclk);
`endif
        rx = stop;
        idle(stop_len);
        rx = 1'b1;
    endtask

    task automatic send_ok(input logic [7:0] b, input int unsigned bclk);
        send_frame(b, bclk, 1'b1, bclk);
        idle(16);
    endtask

    task automatic pop();
        rd_en = 1'b1;
        idle(1);
        rd_en = 1'b0;
    endtask

    task automatic clear_errs();
        err_clr = 1'b1;
        idle(1);
        err_clr = 1'b0;
    endtask

    initial begin
        int unsigned lat;
        logic [7:0]  b;
        int unsigned bclk;
        logic        good;

        vecs[0] = '{data: 8'h01, bclk: 64, exp_count: 3'd1, exp_head: 8'h01, exp_ovr: 1'b0};
        vecs[1] = '{data: 8'h02, bclk: 63, exp_count: 3'd2, exp_head: 8'h01, exp_ovr: 1'b0};
        vecs[2] = '{data: 8'h03, bclk: 65, exp_count: 3'd3, exp_head: 8'h01, exp_ovr: 1'b0};
        vecs[3] = '{data: 8'h04, bclk: 64, exp_count: 3'd4, exp_head: 8'h01, exp_ovr: 1'b0};
        vecs[4] = '{data: 8'h05, bclk: 64, exp_count: 3'd4, exp_head: 8'h01, exp_ovr: 1'b1};

        rst_n   = 1'b0;
        rx      = 1'b1;
        rd_en   = 1'b0;
        err_clr = 1'b0;
        idle(3);
        check_state("reset", 1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
        rst_n = 1'b1;
        idle(5);

        // Single frame with latency measurement from the start edge.
        lat = 0;
        fork
            send_ok(8'hA5, BitClk);
            begin
                for (int c = 1; c <= 800; c++) begin
                    @(negedge clk);
                    if (rx_valid && lat == 0) lat = c;
                end
            end
        join
        check("latency_window", 32'((lat >= StopPos - 4) && (lat <= StopPos + 6)), 32'(1));
        check_state("single", 1'b1, 8'hA5, 3'd1, 1'b0, 1'b0);
        pop();
        check_state("single_pop", 1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
        pop();
        check_state("pop_empty", 1'b0, 8'h00, 3'd0, 1'b0, 1'b0);

        // Glitch rejection, then a normal frame proves the FSM is back in idle.
        rx = 1'b0;
        idle(20);
        rx = 1'b1;
        idle(100);
        check_state("glitch", 1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
        send_ok(8'h5A, BitClk);
        check_state("after_glitch", 1'b1, 8'h5A, 3'd1, 1'b0, 1'b0);
        pop();

        // Overrun table.
        foreach (vecs[i]) begin
            send_ok(vecs[i].data, vecs[i].bclk);
            check($sformatf("ovr_tab%0d.count", i), 32'(fifo_count), 32'(vecs[i].exp_count));
            check($sformatf("ovr_tab%0d.head", i), 32'(rx_data), 32'(vecs[i].exp_head));
            check($sformatf("ovr_tab%0d.overrun", i), 32'(overrun), 32'(vecs[i].exp_ovr));
        end
        for (int i = 1; i <= 4; i++) begin
            check($sformatf("ovr_drain%0d", i), 32'(rx_data), 32'(i));
            pop();
        end
        check_state("ovr_drained", 1'b0, 8'h00, 3'd0, 1'b1, 1'b0);
        clear_errs();
        check_state("ovr_cleared", 1'b0, 8'h00, 3'd0, 1'b0, 1'b0);

        // Full FIFO with a pop landing exactly on the stop sample cycle.
        for (int i = 2; i <= 5; i++) send_ok(8'(i), BitClk);
        check_state("full", 1'b1, 8'h02, 3'd4, 1'b0, 1'b0);
        fork
            send_ok(8'h06, BitClk);
            begin
                idle(StopPos);
                rd_en = 1'b1;
                idle(1);
                rd_en = 1'b0;
            end
        join
        check_state("full_pop", 1'b1, 8'h03, 3'd4, 1'b0, 1'b0);
        for (int i = 3; i <= 6; i++) begin
            check($sformatf("full_drain%0d", i), 32'(rx_data), 32'(i));
            pop();
        end
        check_state("full_drained", 1'b0, 8'h00, 3'd0, 1'b0, 1'b0);

        // Framing error with a held-low line, long enough that a re-armed receiver would push.
        send_frame(8'h3C, BitClk, 1'b0, BitClk + 200);
        check_state("frame_err", 1'b0, 8'h00, 3'd0, 1'b0, 1'b1);
        idle(700);
        check_state("break_no_push", 1'b0, 8'h00, 3'd0, 1'b0, 1'b1);
        send_ok(8'h3C, BitClk);
        check_state("after_break", 1'b1, 8'h3C, 3'd1, 1'b0, 1'b1);
        pop();
        clear_errs();
        check_state("fe_cleared", 1'b0, 8'h00, 3'd0, 1'b0, 1'b0);

        // Rate tolerance at about -3% and +3%.
        send_ok(8'h55, 62);
        check_state("rate_fast", 1'b1, 8'h55, 3'd1, 1'b0, 1'b0);
        pop();
        send_ok(8'h55, 66);
        check_state("rate_slow", 1'b1, 8'h55, 3'd1, 1'b0, 1'b0);
        pop();

        // Randomized frames, pops and clears against the queue model.
        mq.delete();
        m_ovr = 1'b0;
        m_fe  = 1'b0;
        for (int it = 0; it < 24; it++) begin
            b    = 8'($urandom_range(0, 255));
            bclk = 62 + $urandom_range(0, 4);
            good = ($urandom_range(0, 5) != 0);
            send_frame(b, bclk, good, bclk);
            idle(16);
            if (good) begin
                if (mq.size() < Depth) mq.push_back(b);
                else m_ovr = 1'b1;
            end else begin
                m_fe = 1'b1;
            end
            compare_model($sformatf("rand%0d", it));
            if ($urandom_range(0, 1) == 1) begin
                pop();
                if (mq.size() != 0) void'(mq.pop_front());
                compare_model($sformatf("rand%0d_pop", it));
            end
            if ($urandom_range(0, 3) == 0) begin
                clear_errs();
                m_ovr = 1'b0;
                m_fe  = 1'b0;
                compare_model($sformatf("rand%0d_clr", it));
            end
        end

        // Asynchronous reset in the middle of a data bit with bytes and a flag pending.
        send_ok(8'h77, BitClk);
        send_frame(8'h11, BitClk, 1'b0, BitClk);
        idle(16);
        check("pre_reset.valid", 32'(rx_valid), 32'(1));
        check("pre_reset.fe", 32'(frame_err), 32'(1));
        fork
            send_ok(8'h99, BitClk);
            begin
                idle(300);
                #2 rst_n = 1'b0;
                #1 check_state("async_reset", 1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
            end
        join
        rst_n = 1'b1;
        idle(20);
        check_state("post_reset", 1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
        send_ok(8'h42, BitClk);
        check_state("post_reset_frame", 1'b1, 8'h42, 3'd1, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_receiver.md
# uart_receiver

Serial receive path for the UART at $C000-$C0FF. Replaces the constant-high `rx` tie-off. It synchronises the raw RX pin, recovers 8N1 frames with 16x oversampling and mid-bit sampling, and buffers received bytes in a small show-ahead FIFO. The `uart` register file pops that FIFO on CPU reads of its data register.

## Interface
- `CLK_FREQ`, 25000000, system clock in Hz
- `BAUD_RATE`, 9600, line rate in baud
- `FIFO_DEPTH`, 4, receive FIFO entries; power of 2, 2..16

- `clk`  in  1  25 MHz system clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `rx`  in  1  raw serial input, asynchronous to `clk`, idle high
- `rd_en`  in  1  single-cycle pop strobe from the register file
- `err_clr`  in  1  single-cycle clear of the sticky error flags
- `rx_data`  out  8  byte at the FIFO head; 8'h00 when empty
- `rx_valid`  out  1  FIFO not empty
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  number of bytes held
- `overrun`  out  1  sticky: a byte was dropped because the FIFO was full
- `frame_err`  out  1  sticky: a stop bit was sampled low
- `parity_err`  out  1  sticky: parity mismatch; constant 0 unless the macro below is defined

## Operation
- Synchroniser:
  - 2-FF chain on `rx`, reset to 1.
  - All logic uses the synchronised value `rxs`.
- Tick generator:
  - DIV = (CLK_FREQ + BAUD_RATE*8) / (BAUD_RATE*16), integer division.
  - The counter emits a 1-cycle `tick` every DIV clocks.
  - It is forced to 0 on the IDLE->START transition, which aligns ticks to the start edge.
- A 4-bit sample counter `sc` counts ticks within a bit.
- FSM states and transitions:
  - IDLE: on `rxs`==0, go to START and clear `sc`.
  - START: at `sc`==7 on a tick, sample `rxs`.
    - 0: go to DATA and clear `sc`.
    - 1: treat as a glitch and return to IDLE. No flags change.
  - DATA: sample on every tick with `sc`==15 (mid-bit).
    - Shift bits in LSB first.
    - After bit 7, go to PARITY if the macro is defined, else go to STOP.
  - PARITY (macro only): sample at `sc`==15.
    - Even parity: set `parity_err` if the XOR of the data bits and the parity bit is 1.
    - Go to STOP.
  - STOP: sample at `sc`==15.
    - 1: push the byte into the FIFO and go to IDLE.
    - 0: set `frame_err`, discard the byte, and go to BREAK.
  - BREAK: remain until `rxs`==1, then go to IDLE. This prevents a held-low line from producing repeated frames.
- A byte with a parity error is still pushed; `parity_err` flags it.
- FIFO push and pop:
  - Push happens in the STOP sample cycle.
  - Pop happens when `rd_en`=1 and `rx_valid`=1. `rd_en` on an empty FIFO is ignored.
  - Pointers are $clog2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH.
  - `fifo_count` increments on push only, decrements on pop only, and is unchanged on simultaneous push and pop.
- FIFO full:
  - Push without a pop in the same cycle: the byte is dropped and `overrun` is set.
  - Push with a pop in the same cycle: both are accepted and no overrun occurs.
- Sticky flags clear on `err_clr`. If a set event and `err_clr` occur in the same cycle, set wins.

## Timing
- Reset values:
  - FSM in IDLE; counters, pointers and `fifo_count` at 0.
  - `rx_valid`=0, `rx_data`=8'h00, all flags 0.
- Latency from `rx` edge to `rxs`: 2 clocks.
- Start-bit validation occurs 8 ticks after the edge is detected.
- The stop bit is sampled on tick 152 after detection, with ticks numbered from 1 (the start bit is validated on tick 8).
- `rx_valid`, `rx_data` and `fifo_count` update on the clock after the push. `rx_data` is combinational from the FIFO head (show-ahead).
- After a pop, the next byte appears on `rx_data` in the following cycle.
- Back-to-back frames: a start edge in the cycle after the STOP sample is accepted. The FSM is in IDLE by then.
- Reset mid-frame aborts the frame asynchronously, empties the FIFO and clears all flags.
- Sustained rate: one byte per 10 bit-times, or 11 with parity.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - Frame is 8E1.
  - The PARITY state exists and `parity_err` is live.
- Not defined:
  - Frame is 8N1.
  - There is no PARITY state, and `parity_err` is tied to 0.

## Test plan
Bench parameters: CLK_FREQ=6400000, BAUD_RATE=100000, so DIV=4 and one bit is 64 clocks.
- Single frame: send 8'hA5 at nominal rate. `rx_valid` rises about 610 clocks after the start edge, with `rx_data`=8'hA5 and `fifo_count`=1. A pulse on `rd_en` then gives `rx_valid`=0 and `rx_data`=8'h00.
- Glitch rejection: drive a 20-clock low pulse on an idle line. No push occurs, flags stay 0, and the FSM returns to IDLE.
- Overrun: send 5 frames (8'h01..8'h05) with no pops. Result: `fifo_count`=4 and `overrun`=1. Popping 4 times yields 8'h01..8'h04. Then `err_clr` sets `overrun` to 0.
- Full plus simultaneous pop: with the FIFO full, pulse `rd_en` in the STOP sample cycle of frame 8'h06. Result: `overrun`=0, `fifo_count` stays 4, and the tail entry is 8'h06.
- Framing: send 8'h3C with the stop bit low, then hold the line low for 200 clocks. Result: `frame_err`=1, no push, and the FSM stays in BREAK until `rx` returns high. A following 8'h3C is received normally.
- Rate tolerance and reset: send 8'h55 at ±3% baud and expect it received correctly. Assert `rst_n`=0 mid-data-bit: all outputs return to reset values within the same cycle.
